seq_detect_param: RTL and testbench

- Parametrised serial pattern detector; successor to the fixed 2-input "01110" detector FSM.
- Accepts LANES bits per cycle and matches a runtime-loadable pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping matching.
- Reports per-lane match flags, an any-match flag Z and a saturating match counter.
- Sits on the serial bit stream between the input deserialiser and control logic.

---
 rtl/seq_det_pkg.sv | 26 ++
 rtl/seq_det_lane_cmp.sv | 17 +
 rtl/seq_detect_param.sv | 140 ++++++++++++++
 tb/tb_seq_detect_param.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// Holds the reset pattern, the parameter sanity check and the masked window compare.
package seq_det_pkg;

    localparam int PKG_MAX_LEN = 32;

    localparam logic [7:0] SD_DEF_PAT = 8'b0000_1110;
    localparam int         SD_DEF_LEN = 5;
    localparam bit         SD_DEF_OVL = 1'b1;

    // cfg_len must be able to encode MAX_LEN itself; the history needs at least one bit.
    function automatic bit len_w_ok(input int max_len, input int len_w);
        return (max_len >= 2) && (max_len <= PKG_MAX_LEN) && (len_w < 31) &&
               ((1 << len_w) > max_len);
    endfunction

    // Bit 0 of win/pat is the newest bit; only the lowest len bits take part.
    function automatic logic masked_eq(input logic [PKG_MAX_LEN-1:0] win,
                                       input logic [PKG_MAX_LEN-1:0] pat,
                                       input logic [31:0]            len);
        logic [PKG_MAX_LEN-1:0] mask;
        mask = (len >= 32'(PKG_MAX_LEN)) ? '1 : ((32'd1 << len) - 32'd1);
        return ((win ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/seq_det_lane_cmp.sv
// Combinational compare of one MAX_LEN bit window against the active pattern.
// Zero latency, no flow control; the window LSB is the bit the match would end on.
module seq_det_lane_cmp
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic [MAX_LEN-1:0] win,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               raw
);

    assign raw = masked_eq(PKG_MAX_LEN'(win), PKG_MAX_LEN'(pat), 32'(len));

endmodule

// File: rtl/seq_detect_param.sv
// Multi-lane serial pattern detector with runtime pattern, length and overlap mode.
// Outputs registered one cycle after the beat; no backpressure, every valid beat is consumed.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                 LANES   = 2,
    parameter int                 MAX_LEN = 8,
    parameter int                 LEN_W   = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(SD_DEF_PAT),
    parameter int                 DEF_LEN = SD_DEF_LEN,
    parameter bit                 DEF_OVL = SD_DEF_OVL
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               in_valid,
    input  logic [LANES-1:0]   din,
    output logic [LANES-1:0]   match_lane,
    output logic               Z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    localparam int SW    = MAX_LEN - 1 + LANES;
    localparam int SUM_W = CNT_W + $clog2(LANES + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    generate
        if (!len_w_ok(MAX_LEN, LEN_W)) begin : g_bad_params
            $error("seq_detect_param: LEN_W too narrow for MAX_LEN, or MAX_LEN out of range");
        end
    endgenerate

    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   avail;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   pat_len;
    logic               ovl;
    logic [LANES-1:0]   lane_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    logic [SW-1:0]      stream;
    logic [LANES-1:0]   raw;
    logic [LANES-1:0]   hit;
    logic [LEN_W-1:0]   avail_run;
    logic [LEN_W-1:0]   avail_nxt;
    logic [SUM_W-1:0]   pop;
    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               cfg_ok;

    // Oldest history bit at the top, din[0] (newest) at bit 0.
    assign stream = {hist, din};
    assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_MAX);

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            seq_det_lane_cmp #(
                .MAX_LEN (MAX_LEN),
                .LEN_W   (LEN_W)
            ) u_cmp (
                .win (stream[g +: MAX_LEN]),
                .pat (pat),
                .len (pat_len),
                .raw (raw[g])
            );
        end
    endgenerate

    // Walk lanes in arrival order so a non-overlap hit blocks later lanes of the same beat.
    always_comb begin
        avail_run = avail;
        hit       = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (avail_run != LEN_MAX) begin
                avail_run = avail_run + LEN_W'(1);
            end
            hit[i] = raw[i] && (avail_run >= pat_len);
            if (hit[i] && !ovl) begin
                avail_run = '0;
            end
        end
        avail_nxt = avail_run;
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + SUM_W'(hit[i]);
        end
        sum     = SUM_W'(cnt_q) + pop;
        cnt_nxt = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hist    <= '0;
            avail   <= '0;
            pat     <= DEF_PAT;
            pat_len <= LEN_W'(DEF_LEN);
            ovl     <= DEF_OVL;
            lane_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (cfg_load) begin
            lane_q <= '0;
            if (cfg_ok) begin
                pat     <= cfg_pat;
                pat_len <= cfg_len;
                ovl     <= cfg_ovl;
                hist    <= '0;
                avail   <= '0;
                cnt_q   <= '0;
                err_q   <= 1'b0;
            end else begin
                err_q <= 1'b1;
            end
        end else if (in_valid) begin
            hist   <= stream[MAX_LEN-2:0];
            avail  <= avail_nxt;
            lane_q <= hit;
            cnt_q  <= cnt_nxt;
        end else begin
            lane_q <= '0;
        end
    end

    assign match_lane = lane_q;
    assign Z          = |lane_q;
    assign match_cnt  = cnt_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus a random run against a bit-serial model.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pat = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_ovl = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] din = '0;
    logic [1:0] match_lane;
    logic       Z;
    logic [7:0] match_cnt;
    logic       cfg_err;

    int checks = 0;
    int failures = 0;

    // Observations taken at the start of a cycle, and what the model predicted for them.
    logic [1:0] obs_ml;
    logic       obs_z;
    logic [7:0] obs_cnt;
    logic       obs_err;
    logic [1:0] pexp_ml;
    int         pexp_cnt;
    bit         pexp_err;

    // Reference model: plain list of bits since reset/load, indexed by arrival number.
    logic       mq[$];
    longint     idx;
    longint     last_end;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_cnt;
    bit         m_err;
    logic [1:0] m_ml;

    seq_detect_param dut (
        .clk        (clk),
        .clr        (clr),
        .cfg_load   (cfg_load),
        .cfg_pat    (cfg_pat),
        .cfg_len    (cfg_len),
        .cfg_ovl    (cfg_ovl),
        .in_valid   (in_valid),
        .din        (din),
        .match_lane (match_lane),
        .Z          (Z),
        .match_cnt  (match_cnt),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic c, input logic ld, input logic [7:0] p,
                              input logic [3:0] l, input logic o, input logic v,
                              input logic [1:0] d);
        bit match;
        if (c) begin
            mq.delete();
            idx = 0; last_end = 0;
            m_pat = 8'b0000_1110; m_len = 5; m_ovl = 1'b1;
            m_cnt = 0; m_err = 1'b0; m_ml = 2'b00;
        end else if (ld) begin
            m_ml = 2'b00;
            if (l >= 1 && l <= 8) begin
                m_pat = p; m_len = int'(l); m_ovl = o;
                mq.delete();
                last_end = idx;
                m_cnt = 0; m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (v) begin
            m_ml = 2'b00;
            for (int i = 1; i >= 0; i--) begin
                idx++;
                mq.push_back(d[i]);
                if (mq.size() > 16) void'(mq.pop_front());
                // A match must start after the end of the last blocking match (or load/reset).
                if (idx - last_end >= longint'(m_len)) begin
                    match = 1'b1;
                    for (int k = 0; k < m_len; k++) begin
                        if (mq[mq.size() - 1 - k] !== m_pat[k]) match = 1'b0;
                    end
                    if (match) begin
                        m_ml[i] = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                        if (!m_ovl) last_end = idx;
                    end
                end
            end
        end else begin
            m_ml = 2'b00;
        end
    endtask

    task automatic cyc(input logic c, input logic ld, input logic [7:0] p, input logic [3:0] l,
                       input logic o, input logic v, input logic [1:0] d);
        @(negedge clk);
        obs_ml = match_lane; obs_z = Z; obs_cnt = match_cnt; obs_err = cfg_err;
        pexp_ml = m_ml; pexp_cnt = m_cnt; pexp_err = m_err;
        clr = c; cfg_load = ld; cfg_pat = p; cfg_len = l; cfg_ovl = o; in_valid = v; din = d;
        model_step(c, ld, p, l, o, v, d);
    endtask

    task automatic beat(input logic [1:0] d);
        cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, d);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cyc(1'b0, 1'b1, p, l, o, 1'b0, 2'b00);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 2'b11);
        idle();
        checks++; if (obs_ml !== 2'b00) begin failures++; $display("FAIL reset_ml: got %b expected 00", obs_ml); end
        checks++; if (obs_z !== 1'b0) begin failures++; $display("FAIL reset_z: got %b expected 0", obs_z); end
        checks++; if (obs_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", obs_cnt); end
        checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", obs_err); end
    endtask

    task automatic test_default_detect();
        beat(2'b01);
        beat(2'b11);
        checks++; if (obs_z !== 1'b0) begin failures++; $display("FAIL def_beat1_z: got %b expected 0", obs_z); end
        beat(2'b00);
        checks++; if (obs_z !== 1'b0) begin failures++; $display("FAIL def_beat2_z: got %b expected 0", obs_z); end
        idle();
        checks++; if (obs_ml !== 2'b10) begin failures++; $display("FAIL def_beat3_ml: got %b expected 10", obs_ml); end
        checks++; if (obs_z !== 1'b1) begin failures++; $display("FAIL def_beat3_z: got %b expected 1", obs_z); end
        checks++; if (obs_cnt !== 8'd1) begin failures++; $display("FAIL def_cnt: got %0d expected 1", obs_cnt); end
        idle();
        checks++; if (obs_z !== 1'b0) begin failures++; $display("FAIL def_idle_z: got %b expected 0", obs_z); end
    endtask

    // Bits 0101010 followed by a 0 pad: "0101" ends at bits 4 and 6 when overlapping.
    task automatic test_overlap();
        load(8'b0000_0101, 4'd4, 1'b1);
        beat(2'b01); beat(2'b01); beat(2'b01); beat(2'b00);
        idle();
        checks++; if (obs_cnt !== 8'd2) begin failures++; $display("FAIL ovl1_cnt: got %0d expected 2", obs_cnt); end
        load(8'b0000_0101, 4'd4, 1'b0);
        beat(2'b01); beat(2'b01); beat(2'b01); beat(2'b00);
        idle();
        checks++; if (obs_cnt !== 8'd1) begin failures++; $display("FAIL ovl0_cnt: got %0d expected 1", obs_cnt); end
    endtask

    task automatic test_warmup_reset();
        load(8'b0000_0000, 4'd2, 1'b1);
        beat(2'b01);
        beat(2'b00);
        checks++; if (obs_ml !== 2'b00) begin failures++; $display("FAIL warmup_ml: got %b expected 00", obs_ml); end
        idle();
        checks++; if (obs_ml !== 2'b01) begin failures++; $display("FAIL warmup_hit_ml: got %b expected 01", obs_ml); end
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 2'b00);
        beat(2'b01); beat(2'b11);
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 2'b00);
        beat(2'b00);
        idle();
        checks++; if (obs_ml !== 2'b00) begin failures++; $display("FAIL split_reset_ml: got %b expected 00", obs_ml); end
        checks++; if (obs_cnt !== 8'd0) begin failures++; $display("FAIL split_reset_cnt: got %0d expected 0", obs_cnt); end
        beat(2'b01); beat(2'b11); beat(2'b00);
        idle();
        checks++; if (obs_ml !== 2'b10) begin failures++; $display("FAIL revert_ml: got %b expected 10", obs_ml); end
    endtask

    task automatic test_cfg_err();
        load(8'hFF, 4'd0, 1'b0);
        idle();
        checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL err_len0: got %b expected 1", obs_err); end
        checks++; if (obs_cnt !== 8'd1) begin failures++; $display("FAIL err_keep_cnt: got %0d expected 1", obs_cnt); end
        load(8'hFF, 4'd9, 1'b0);
        idle();
        checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL err_len9: got %b expected 1", obs_err); end
        beat(2'b01); beat(2'b11); beat(2'b00);
        idle();
        checks++; if (obs_ml !== 2'b10) begin failures++; $display("FAIL err_detect_ml: got %b expected 10", obs_ml); end
        checks++; if (obs_cnt !== 8'd2) begin failures++; $display("FAIL err_detect_cnt: got %0d expected 2", obs_cnt); end
        // Load together with a beat: the beat carrying the leading 0 must be dropped.
        cyc(1'b0, 1'b1, 8'b0000_1110, 4'd5, 1'b1, 1'b1, 2'b01);
        beat(2'b11);
        checks++; if (obs_ml !== 2'b00) begin failures++; $display("FAIL prio_ml: got %b expected 00", obs_ml); end
        checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL prio_err: got %b expected 0", obs_err); end
        checks++; if (obs_cnt !== 8'd0) begin failures++; $display("FAIL prio_cnt: got %0d expected 0", obs_cnt); end
        beat(2'b00);
        idle();
        checks++; if (obs_ml !== 2'b00) begin failures++; $display("FAIL prio_drop_ml: got %b expected 00", obs_ml); end
    endtask

    task automatic test_saturation();
        load(8'b0000_0001, 4'd1, 1'b1);
        for (int n = 1; n <= 130; n++) begin
            beat(2'b11);
            if (n >= 2) begin
                checks++; if (obs_ml !== 2'b11) begin failures++; $display("FAIL sat_ml beat %0d: got %b expected 11", n - 1, obs_ml); end
            end
            if (n == 128) begin
                checks++; if (obs_cnt !== 8'd254) begin failures++; $display("FAIL sat_cnt_254: got %0d expected 254", obs_cnt); end
            end
        end
        idle();
        checks++; if (obs_cnt !== 8'd255) begin failures++; $display("FAIL sat_cnt: got %0d expected 255", obs_cnt); end
        idle();
        checks++; if (obs_cnt !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d expected 255", obs_cnt); end
        checks++; if (obs_ml !== 2'b00) begin failures++; $display("FAIL sat_idle_ml: got %b expected 00", obs_ml); end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 10000; n++) begin
            r = int'($urandom_range(0, 199));
            if (r < 1) begin
                cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'($urandom), 2'($urandom));
            end else if (r < 5) begin
                cyc(1'b0, 1'b1, 8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom),
                    1'($urandom), 2'($urandom));
            end else if (r < 30) begin
                idle();
            end else begin
                beat(2'($urandom));
            end
            checks++; if (obs_ml !== pexp_ml) begin failures++; $display("FAIL rnd_ml step %0d: got %b expected %b", n, obs_ml, pexp_ml); end
            checks++; if (obs_z !== (|pexp_ml)) begin failures++; $display("FAIL rnd_z step %0d: got %b expected %b", n, obs_z, |pexp_ml); end
            checks++; if (obs_cnt !== 8'(pexp_cnt)) begin failures++; $display("FAIL rnd_cnt step %0d: got %0d expected %0d", n, obs_cnt, pexp_cnt); end
            checks++; if (obs_err !== pexp_err) begin failures++; $display("FAIL rnd_err step %0d: got %b expected %b", n, obs_err, pexp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_default_detect();
        test_overlap();
        test_warmup_reset();
        test_cfg_err();
        test_saturation();
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 2'b00);
        test_random();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
